dip_debounce: RTL and testbench
===============================

DIP_DEBOUNCE -- requirements
Module: dip_debounce

Interface
REQ-001 SHALL have parameter WIDTH, default 8, the number of switch channels.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 1000000 (20 ms at 50 MHz), the consecutive-cycle stability threshold; legal range is at least 2.
REQ-003 SHALL have parameter INVERT, default 0; when 1, each raw input is inverted before synchronization, for active-low switches.
REQ-004 SHALL have port clk, input, 1 bit: the single 50 MHz clock; all state is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port sw_raw, input, WIDTH bits: asynchronous switch pins (trainer_dip).
REQ-007 SHALL have port sw_out, output, WIDTH bits: debounced level, driven to the LEDs.
REQ-008 SHALL have port sw_rise, output, WIDTH bits: one-cycle pulse per bit when sw_out goes 0->1.
REQ-009 SHALL have port sw_fall, output, WIDTH bits: one-cycle pulse per bit when sw_out goes 1->0.
REQ-010 SHALL have port changed, output, 1 bit: OR of sw_rise and sw_fall, in the same cycle.

Function
REQ-011 SHALL pass each bit of (sw_raw XOR {WIDTH{INVERT}}) through a 2-flop synchronizer; the second flop is sync[i].
REQ-012 SHALL give each bit an independent counter cnt[i], $clog2(DEBOUNCE_CYCLES) bits wide.
REQ-013 SHALL clear cnt[i] to 0 on the next edge whenever sync[i] == sw_out[i].
REQ-014 SHALL increment cnt[i] whenever sync[i] != sw_out[i] and cnt[i] < DEBOUNCE_CYCLES-1.
REQ-015 SHALL, on the edge where sync[i] != sw_out[i] and cnt[i] == DEBOUNCE_CYCLES-1, load sw_out[i] <= sync[i] and clear cnt[i]; this is DEBOUNCE_CYCLES consecutive differing cycles.
REQ-016 SHALL treat any single-cycle return of sync[i] to sw_out[i] during counting as a glitch, restarting the count from 0.
REQ-017 SHALL give a fixed latency: a clean pin step is visible on sw_out exactly DEBOUNCE_CYCLES+2 clocks after the first edge that samples it.
REQ-018 SHALL register sw_rise[i] and sw_fall[i] so they are high only in the first cycle that sw_out[i] shows the new value, and low otherwise.
REQ-019 SHALL operate bits independently; simultaneous qualification of several bits SHALL update all of them, with their pulses, in the same cycle.
REQ-020 SHALL never saturate or wrap cnt[i] beyond DEBOUNCE_CYCLES-1.
REQ-021 SHALL produce, for a switch held continuously, no further pulses after the single qualifying transition.

Reset
REQ-022 SHALL, while rst_n is low, asynchronously force the synchronizer flops, cnt, sw_out, sw_rise, sw_fall and changed to 0.
REQ-023 SHALL, after rst_n deasserts, debounce switches held at 1 as normal 0->1 transitions, each producing one sw_rise pulse after DEBOUNCE_CYCLES+2 cycles.
REQ-024 SHALL, on reset asserted mid-count, discard the partial count with no pulse emitted.

Structure
REQ-025 SHALL place the defaults DIP_WIDTH=8 and DIP_DEBOUNCE_CYCLES=1000000 in the shared project constants package/header, for use by the top level.
REQ-026 SHALL use one sub-module, debounce_bit (synchronizer, counter, stable flop and edge pulses for one channel), instantiated WIDTH times by generate.
REQ-027 SHALL let the top level tie sw_raw to trainer_dip and led to sw_out; the pulse outputs are available for later stages.

Verification (bench uses DEBOUNCE_CYCLES=16, WIDTH=8, INVERT=0)
REQ-028 SHALL cover a clean step: sw_raw 0x00->0x01 held -> sw_out = 0x01 exactly 18 clocks later, sw_rise = 0x01 for 1 cycle, changed = 1 for 1 cycle.
REQ-029 SHALL cover bounce: bit 3 toggles every 5 cycles for 60 cycles, then holds 1 -> sw_out[3] stays 0 during bouncing, rises 18 clocks after the final toggle, and exactly one sw_rise[3] pulse.
REQ-030 SHALL cover a glitch: bit 7 high for 15 cycles, then low -> no change on sw_out, and zero pulses.
REQ-031 SHALL cover simultaneous edges: 0xF0 stable, then 0x0F -> after 18 clocks sw_out = 0x0F, sw_rise = 0x0F and sw_fall = 0xF0 in the same single cycle.
REQ-032 SHALL cover reset: rst_n low mid-count (cnt = 10) -> all outputs 0 immediately; with sw_raw = 0xAA held after release, sw_out = 0xAA 18 clocks later, and one sw_rise = 0xAA pulse.
REQ-033 SHALL cover INVERT=1: sw_raw held 0xFF from reset -> sw_out stays 0x00 and no pulses occur.

Source files
------------

// File: rtl/dip_debounce_pkg.sv
// Shared project constants for the DIP switch debouncer.
// Defaults target the trainer board: 8 switches, 20 ms at 50 MHz.
package dip_debounce_pkg;

    localparam int unsigned DIP_WIDTH           = 8;
    localparam int unsigned DIP_DEBOUNCE_CYCLES = 1000000;

endpackage

// File: rtl/debounce_bit.sv
// One debounced switch channel: 2-flop synchronizer, stability counter,
// stable level flop and registered rise/fall pulses.
module debounce_bit #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    logic            meta_q, sync_q;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            level_q, level_d;
    logic            rise_q, rise_d;
    logic            fall_q, fall_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= raw;
            sync_q <= meta_q;
        end
    end

    // Any cycle where the synchronized input matches the stable level restarts the count.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (sync_q != level_q) begin
            if (cnt_q == CntMax) begin
                level_d = sync_q;
                rise_d  = sync_q;
                fall_d  = ~sync_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/dip_debounce.sv
// Debouncer for a bank of DIP switches; sw_out drives the LEDs, the
// pulse outputs are for later stages.
module dip_debounce
    import dip_debounce_pkg::*;
#(
    parameter int unsigned WIDTH           = DIP_WIDTH,
    parameter int unsigned DEBOUNCE_CYCLES = DIP_DEBOUNCE_CYCLES,
    parameter bit          INVERT          = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_out,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             changed
);

    logic [WIDTH-1:0] raw_adj;

    // Active-low switches are flipped before synchronization.
    assign raw_adj = sw_raw ^ {WIDTH{INVERT}};

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_bit (
            .clk  (clk),
            .rst_n(rst_n),
            .raw  (raw_adj[i]),
            .level(sw_out[i]),
            .rise (sw_rise[i]),
            .fall (sw_fall[i])
        );
    end

    assign changed = |(sw_rise | sw_fall);

endmodule

// File: tb/tb_dip_debounce.sv
// Directed bench for dip_debounce with DEBOUNCE_CYCLES=16, WIDTH=8.
module tb_dip_debounce;

    localparam int unsigned W   = 8;
    localparam int unsigned D   = 16;
    localparam int unsigned LAT = D + 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] sw_raw = '0;
    logic [W-1:0] sw_out, sw_rise, sw_fall;
    logic         changed;

    logic [W-1:0] inv_raw = 8'hFF;
    logic [W-1:0] inv_out, inv_rise, inv_fall;
    logic         inv_changed;
    int           inv_pulses = 0;

    int checks = 0;
    int failures = 0;

    always #10 clk = ~clk;

    dip_debounce #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .INVERT(1'b0)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .sw_raw (sw_raw),
        .sw_out (sw_out),
        .sw_rise(sw_rise),
        .sw_fall(sw_fall),
        .changed(changed)
    );

    dip_debounce #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .INVERT(1'b1)) dut_inv (
        .clk    (clk),
        .rst_n  (rst_n),
        .sw_raw (inv_raw),
        .sw_out (inv_out),
        .sw_rise(inv_rise),
        .sw_fall(inv_fall),
        .changed(inv_changed)
    );

    always @(posedge clk) begin
        if (inv_changed || (inv_rise != '0) || (inv_fall != '0)) inv_pulses++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        sw_raw = '0;
        #5;
        checks++;
        if ({sw_out, sw_rise, sw_fall, changed} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got out=%h rise=%h fall=%h chg=%b want all 0",
                     sw_out, sw_rise, sw_fall, changed);
        end
        tick();
        tick();
        rst_n = 1'b1;
        for (int n = 0; n < 20; n++) tick();
        checks++;
        if ({sw_out, sw_rise, sw_fall, changed} !== '0) begin
            failures++;
            $display("FAIL reset_idle got out=%h rise=%h fall=%h chg=%b want all 0",
                     sw_out, sw_rise, sw_fall, changed);
        end
    endtask

    // Runs LAT+2 cycles after a step from old_v to new_v, checking level and pulse timing.
    task automatic run_step(input string name, input logic [W-1:0] old_v,
                            input logic [W-1:0] new_v);
        logic [W-1:0] exp_out, exp_rise, exp_fall;
        logic         exp_chg;
        sw_raw = new_v;
        for (int n = 1; n <= int'(LAT) + 2; n++) begin
            tick();
            exp_out  = (n >= int'(LAT)) ? new_v : old_v;
            exp_rise = (n == int'(LAT)) ? (new_v & ~old_v) : '0;
            exp_fall = (n == int'(LAT)) ? (~new_v & old_v) : '0;
            exp_chg  = (exp_rise != '0) || (exp_fall != '0);
            checks++;
            if (sw_out !== exp_out || sw_rise !== exp_rise || sw_fall !== exp_fall
                || changed !== exp_chg) begin
                failures++;
                $display("FAIL %s cycle %0d got out=%h rise=%h fall=%h chg=%b want out=%h rise=%h fall=%h chg=%b",
                         name, n, sw_out, sw_rise, sw_fall, changed,
                         exp_out, exp_rise, exp_fall, exp_chg);
            end
        end
    endtask

    task automatic test_clean_step();
        run_step("clean_step", 8'h00, 8'h01);
    endtask

    task automatic test_bounce();
        int rises = 0;
        int rise_cycle = -1;
        for (int t = 0; t < 60; t++) begin
            if (t % 5 == 0) sw_raw[3] = ~sw_raw[3];
            tick();
            checks++;
            if (sw_out !== 8'h01 || sw_rise !== 8'h00 || sw_fall !== 8'h00) begin
                failures++;
                $display("FAIL bounce_hold t=%0d got out=%h rise=%h fall=%h want out=01 no pulses",
                         t, sw_out, sw_rise, sw_fall);
            end
        end
        sw_raw[3] = 1'b1;
        for (int n = 1; n <= int'(LAT) + 4; n++) begin
            tick();
            if (sw_rise[3]) begin
                rises++;
                rise_cycle = n;
            end
            if (n == int'(LAT) - 1) begin
                checks++;
                if (sw_out !== 8'h01) begin
                    failures++;
                    $display("FAIL bounce_early got out=%h want 01", sw_out);
                end
            end
        end
        checks++;
        if (sw_out !== 8'h09) begin
            failures++;
            $display("FAIL bounce_final got out=%h want 09", sw_out);
        end
        checks++;
        if (rises != 1 || rise_cycle != int'(LAT)) begin
            failures++;
            $display("FAIL bounce_pulse got %0d pulses at cycle %0d want 1 at cycle %0d",
                     rises, rise_cycle, LAT);
        end
    endtask

    // 15 high cycles brings the counter to DEBOUNCE_CYCLES-1 without qualifying.
    task automatic test_glitch();
        int pulses = 0;
        sw_raw[7] = 1'b1;
        for (int n = 0; n < 15; n++) tick();
        sw_raw[7] = 1'b0;
        for (int n = 0; n < 30; n++) begin
            tick();
            if (changed || sw_rise != '0 || sw_fall != '0) pulses++;
            checks++;
            if (sw_out !== 8'h09) begin
                failures++;
                $display("FAIL glitch_level cycle %0d got out=%h want 09", n, sw_out);
            end
        end
        checks++;
        if (pulses != 0) begin
            failures++;
            $display("FAIL glitch_pulses got %0d want 0", pulses);
        end
    endtask

    task automatic test_simultaneous();
        run_step("to_f0", 8'h09, 8'hF0);
        run_step("simultaneous", 8'hF0, 8'h0F);
    endtask

    task automatic test_reset_mid_count();
        int rises = 0;
        sw_raw = 8'hAA;
        for (int n = 0; n < 12; n++) tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({sw_out, sw_rise, sw_fall, changed} !== '0) begin
            failures++;
            $display("FAIL reset_mid got out=%h rise=%h fall=%h chg=%b want all 0",
                     sw_out, sw_rise, sw_fall, changed);
        end
        tick();
        tick();
        rst_n = 1'b1;
        for (int n = 1; n <= int'(LAT) + 2; n++) begin
            tick();
            if (sw_rise != '0) rises++;
            checks++;
            if (sw_out !== ((n >= int'(LAT)) ? 8'hAA : 8'h00) || sw_fall !== 8'h00
                || sw_rise !== ((n == int'(LAT)) ? 8'hAA : 8'h00)) begin
                failures++;
                $display("FAIL reset_release cycle %0d got out=%h rise=%h fall=%h",
                         n, sw_out, sw_rise, sw_fall);
            end
        end
        checks++;
        if (rises != 1) begin
            failures++;
            $display("FAIL reset_release_pulses got %0d want 1", rises);
        end
    endtask

    task automatic test_invert();
        checks++;
        if (inv_out !== 8'h00) begin
            failures++;
            $display("FAIL invert_level got out=%h want 00", inv_out);
        end
        checks++;
        if (inv_pulses != 0) begin
            failures++;
            $display("FAIL invert_pulses got %0d want 0", inv_pulses);
        end
    endtask

    initial begin
        test_reset();
        test_clean_step();
        test_bounce();
        test_glitch();
        test_simultaneous();
        test_reset_mid_count();
        test_invert();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
